// File: rtl/param_updown_counter.sv
// Modulo-(MAX+1) up/down counter with an enable prescaler, parallel load, terminal-count pulse and sticky overflow flag.
// Define COUNT_SATURATE_EN to clamp at 0/MAX instead of wrapping.
module param_updown_counter #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // Value taken when a step runs past the end of the range.
`ifdef COUNT_SATURATE_EN
    localparam logic [WIDTH-1:0] LIMIT_UP = MAX_V;
    localparam logic [WIDTH-1:0] LIMIT_DN = '0;
`else
    localparam logic [WIDTH-1:0] LIMIT_UP = '0;
    localparam logic [WIDTH-1:0] LIMIT_DN = MAX_V;
`endif

    logic [PRE_W-1:0] pre_reg,   pre_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg,    tc_next;
    logic             ovf_reg,   ovf_next;

    logic             step;
    logic             at_max;
    logic             at_min;
    logic             limit_hit;
    logic [WIDTH-1:0] load_clamped;

    assign step         = en & ~load & (pre_reg == PRE_LAST);
    assign at_max       = (count_reg == MAX_V);
    assign at_min       = (count_reg == '0);
    assign limit_hit    = step & (up_dn ? at_max : at_min);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Load restarts the prescaler so the next step is a full period away.
    always_comb begin
        pre_next = pre_reg;
        if (load) begin
            pre_next = '0;
        end else if (en) begin
            pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_clamped;
        end else if (step) begin
            if (up_dn) begin
                count_next = at_max ? LIMIT_UP : count_reg + 1'b1;
            end else begin
                count_next = at_min ? LIMIT_DN : count_reg - 1'b1;
            end
        end
    end

    // A limit hit wins over a simultaneous clear so the event is never lost.
    always_comb begin
        tc_next  = limit_hit;
        ovf_next = limit_hit | (ovf_reg & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg   <= '0;
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            pre_reg   <= pre_next;
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count_out = count_reg;
    assign tc        = tc_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4, MAX=9, PRESCALE=2): directed scenarios
// followed by randomized traffic, checked against an arithmetic reference model.
module tb_param_updown_counter;

    localparam int WIDTH    = 4;
    localparam int MAX      = 9;
    localparam int PRESCALE = 2;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             en       = 1'b0;
    logic             up_dn    = 1'b0;
    logic             load     = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             ovf_clr  = 1'b0;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             ovf;

    param_updown_counter #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .ovf_clr   (ovf_clr),
        .count_out (count_out),
        .tc        (tc),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model state: plain integers, advanced by the rules of the counter.
    int   m_count = 0;
    int   m_pre   = 0;
    bit   m_tc    = 1'b0;
    bit   m_ovf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            m_count = 0;
            m_pre   = 0;
            m_tc    = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (load) begin
                m_count = (int'(load_val) > MAX) ? MAX : int'(load_val);
                m_pre   = 0;
            end else if (en) begin
                if (m_pre == PRESCALE - 1) begin
                    m_pre = 0;
                    if (up_dn) begin
                        m_tc = (m_count == MAX);
`ifdef COUNT_SATURATE_EN
                        m_count = (m_count + 1 > MAX) ? MAX : m_count + 1;
`else
                        m_count = (m_count + 1) % (MAX + 1);
`endif
                    end else begin
                        m_tc = (m_count == 0);
`ifdef COUNT_SATURATE_EN
                        m_count = (m_count == 0) ? 0 : m_count - 1;
`else
                        m_count = (m_count + MAX) % (MAX + 1);
`endif
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (m_tc) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        exp_q.push_back({m_count[WIDTH-1:0], m_tc, m_ovf});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            $display("txn %0d: count_out=%0d tc=%0b ovf=%0b (model %0d/%0b/%0b)",
                     txn, count_out, tc, ovf, mon_e.count, mon_e.tc, mon_e.ovf);
            check("count_out", 32'(count_out), 32'(mon_e.count));
            check("tc",        32'(tc),        32'(mon_e.tc));
            check("ovf",       32'(ovf),       32'(mon_e.ovf));
        end
    end

    task automatic cyc(input logic e, input logic u, input logic l,
                       input logic [WIDTH-1:0] lv, input logic c);
        @(negedge clk);
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv;
        ovf_clr  = c;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count_out), 32'd0);
        check({tag, "_tc"},    32'(tc),        32'd0);
        check({tag, "_ovf"},   32'(ovf),       32'd0);
    endtask

    initial begin
        // Inputs are ignored while reset is held.
        repeat (3) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
        #1 check_reset_state("reset_init");
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        #2 reset_n = 1'b1;

        // Count up through a full wrap.
        repeat (20) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Out-of-range load clamps to MAX, then wraps up to 0.
        cyc(1'b1, 1'b1, 1'b1, 4'd13, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Down wrap coinciding with ovf_clr, then a lone clear.
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Asynchronous reset mid-prescale at count 6.
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_state("reset_async");
        repeat (3) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        #2 reset_n = 1'b1;
        repeat (4) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Randomized traffic.
        repeat (300) cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 7) == 0));

        // Approach MAX from 8 (wraps, or holds when saturating).
        cyc(1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
